// File: rtl/b13_req_collector.sv
// b13_req_collector: sticky request capture with mask, frozen snapshot to the priority encoder, and ack-based clear; overflow flags under REQCOL_OVERFLOW_EN.
module b13_req_collector #(
  parameter int OUT_SIZE = 4,
  localparam int IN_SIZE = 1 << OUT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_SIZE-1:0]  req,
  input  logic                mask_we,
  input  logic [IN_SIZE-1:0]  mask_wdata,
  output logic [IN_SIZE-1:0]  vec_out,
  output logic                enc_enable,
  input  logic                ack,
  input  logic [OUT_SIZE-1:0] ack_idx,
  output logic                ack_err,
  output logic [OUT_SIZE:0]   pend_cnt,
  output logic [IN_SIZE-1:0]  overflow,
  input  logic                ovf_clr
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state_q, state_d;
  logic [IN_SIZE-1:0] pending_q, pending_d, mask_q, mask_d, snap_q, snap_d, clr_vec, avail;
  logic [OUT_SIZE:0] cnt_q, cnt_d;
  logic err_q, err_d, busy, ack_ok;
  always_comb begin
    busy = state_q == PRESENT;
    avail = pending_q & ~mask_q;
    ack_ok = busy && ack && snap_q[ack_idx];
    clr_vec = ack_ok ? IN_SIZE'(1) << ack_idx : '0;
    pending_d = (pending_q & ~clr_vec) | req;
    mask_d = mask_we ? mask_wdata : mask_q;
    err_d = busy && ack && !snap_q[ack_idx];
    cnt_d = (OUT_SIZE+1)'($countones(pending_d));
    state_d = busy ? (ack_ok ? IDLE : PRESENT) : (|avail ? PRESENT : IDLE);
    snap_d = (!busy && |avail) ? avail : snap_q;
    enc_enable = busy;
    vec_out = busy ? snap_q : '0;
    ack_err = err_q;
    pend_cnt = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= '0;
      mask_q <= '0;
      snap_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      mask_q <= mask_d;
      snap_q <= snap_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`ifdef REQCOL_OVERFLOW_EN
  logic [IN_SIZE-1:0] ovf_q, ovf_d;
  // a request landing on a still-pending, not-being-cleared line is lost
  always_comb ovf_d = (ovf_clr ? '0 : ovf_q) | (req & pending_q & ~clr_vec);
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else ovf_q <= ovf_d;
  end
  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow = '0;
`endif
endmodule

// File: tb/tb_b13_req_collector.sv
// tb_b13_req_collector: table-driven directed vectors plus hand-written multi-cycle sequences.
module tb_b13_req_collector;
  logic clk = 1'b0;
  logic rst, mask_we, ack, ovf_clr, enc_enable, ack_err;
  logic [15:0] req, mask_wdata, vec_out, overflow;
  logic [3:0] ack_idx;
  logic [4:0] pend_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  b13_req_collector dut (
    .clk(clk), .rst(rst), .req(req), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .vec_out(vec_out), .enc_enable(enc_enable), .ack(ack), .ack_idx(ack_idx),
    .ack_err(ack_err), .pend_cnt(pend_cnt), .overflow(overflow), .ovf_clr(ovf_clr)
  );
  typedef struct {
    logic rst; logic [15:0] req; logic mwe; logic [15:0] mwd; logic ack; logic [3:0] idx; logic oclr;
    logic [15:0] ev; logic ee; logic eerr; logic [4:0] ecnt; logic [15:0] eovf;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic r, input logic [15:0] rq, input logic mwe, input logic [15:0] mwd,
                     input logic a, input logic [3:0] idx, input logic oc, input logic [15:0] ev,
                     input logic ee, input logic eerr, input logic [4:0] ecnt, input logic [15:0] eovf);
    vec_t v;
    v.rst = r; v.req = rq; v.mwe = mwe; v.mwd = mwd; v.ack = a; v.idx = idx; v.oclr = oc;
    v.ev = ev; v.ee = ee; v.eerr = eerr; v.ecnt = ecnt;
`ifdef REQCOL_OVERFLOW_EN
    v.eovf = eovf;
`else
    v.eovf = 16'h0;
`endif
    tv.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [15:0] rq, input logic mwe, input logic [15:0] mwd,
                      input logic a, input logic [3:0] idx, input logic oc);
    rst = r; req = rq; mask_we = mwe; mask_wdata = mwd; ack = a; ack_idx = idx; ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wait_en(input int budget);
    int n = 0;
    while (!enc_enable && n < budget) begin
      idle();
      n++;
    end
    chk("wait_enable", {31'b0, enc_enable}, 32'd1);
  endtask
  initial begin
    rst = 1; req = 0; mask_we = 0; mask_wdata = 0; ack = 0; ack_idx = 0; ovf_clr = 0;
    //  rst req     mwe mwd     ack idx oclr  vec     en err cnt ovf
    add(1, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0028, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 2, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0028, 1, 0, 2, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 3, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0020, 1, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 5, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0001, 1, 16'h1, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0000, 1, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0001, 1, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0100, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0100, 1, 0, 1, 16'h0000);
    add(0, 16'h0004, 0, 16'h0, 0, 0, 0, 16'h0100, 1, 0, 2, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 2, 0, 16'h0100, 1, 1, 2, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0100, 1, 0, 2, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 8, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0004, 1, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 2, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 3, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0020, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0020, 0, 16'h0, 0, 0, 0, 16'h0020, 1, 0, 1, 16'h0020);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 1, 16'h0020, 1, 0, 1, 16'h0000);
    add(0, 16'h0020, 0, 16'h0, 1, 5, 0, 16'h0000, 0, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0020, 1, 0, 1, 16'h0000);
    add(0, 16'h0020, 0, 16'h0, 0, 0, 1, 16'h0020, 1, 0, 1, 16'h0020);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 1, 16'h0020, 1, 0, 1, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 1, 5, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0007, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 3, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0007, 1, 0, 3, 16'h0000);
    add(1, 16'h0100, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    add(0, 16'h0000, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].req, tv[i].mwe, tv[i].mwd, tv[i].ack, tv[i].idx, tv[i].oclr);
      chk($sformatf("vec_out[%0d]", i), {16'b0, vec_out}, {16'b0, tv[i].ev});
      chk($sformatf("enc_enable[%0d]", i), {31'b0, enc_enable}, {31'b0, tv[i].ee});
      chk($sformatf("ack_err[%0d]", i), {31'b0, ack_err}, {31'b0, tv[i].eerr});
      chk($sformatf("pend_cnt[%0d]", i), {27'b0, pend_cnt}, {27'b0, tv[i].ecnt});
      chk($sformatf("overflow[%0d]", i), {16'b0, overflow}, {16'b0, tv[i].eovf});
    end
    // mask write while presenting must not disturb the snapshot
    step(0, 16'h0003, 0, 0, 0, 0, 0);
    wait_en(5);
    chk("seq_vec", {16'b0, vec_out}, 32'h0003);
    chk("seq_cnt", {27'b0, pend_cnt}, 32'd2);
    step(0, 0, 1, 16'hffff, 0, 0, 0);
    chk("seq_mask_hold_vec", {16'b0, vec_out}, 32'h0003);
    chk("seq_mask_hold_en", {31'b0, enc_enable}, 32'd1);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("seq_ack_en", {31'b0, enc_enable}, 32'd0);
    chk("seq_ack_cnt", {27'b0, pend_cnt}, 32'd1);
    idle();
    idle();
    chk("seq_masked_idle", {31'b0, enc_enable}, 32'd0);
    step(0, 0, 1, 16'h0000, 0, 0, 0);
    chk("seq_unmask_gap", {31'b0, enc_enable}, 32'd0);
    idle();
    chk("seq_unmask_en", {31'b0, enc_enable}, 32'd1);
    chk("seq_unmask_vec", {16'b0, vec_out}, 32'h0002);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("seq_final_cnt", {27'b0, pend_cnt}, 32'd0);
    chk("seq_final_err", {31'b0, ack_err}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
